// File: rtl/time_executor.sv
`default_nettype none
// ============================================================================
// Module   : time_executor
// Purpose  : Consumer end of the operation bus. Decodes the packed OPER word
//            {value, opcode} and applies it to a time-of-day seconds counter
//            that advances on a 1 Hz TICK enable and wraps modulo one day.
//            An iterative-subtraction converter turns the count into
//            HOUR/MINUTE/SECOND for the display path.
// Ports    : CLK        - clock, all state on rising edge
//            RST_N      - asynchronous active-low reset
//            OPER       - packed operation word {value, opcode}
//            OPER_VALID - one-cycle strobe, OPER holds a new operation
//            TICK       - one-cycle 1 Hz enable, advance count by one
//            TIME_CNT   - current seconds count, 0..day_sec-1
//            HOUR/MINUTE/SECOND - last completed conversion
//            UPD        - one-cycle pulse when HOUR/MINUTE/SECOND are written
//            BUSY       - converter active
//            OP_ERR     - sticky illegal-operation flag (ILLEGAL_OP_FLAG_EN)
// Options  : define ILLEGAL_OP_FLAG_EN to add the OP_ERR port and logic.
// Revision : 1.0 - initial release
// ============================================================================
module time_executor #(
  parameter int time_buff_size = 18,
  parameter int oper_l         = 3,
  parameter int day_sec        = 86400
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic [time_buff_size+oper_l-1:0] OPER,
  input  logic                             OPER_VALID,
  input  logic                             TICK,
  output logic [16:0]                      TIME_CNT,
  output logic [4:0]                       HOUR,
  output logic [5:0]                       MINUTE,
  output logic [5:0]                       SECOND,
  output logic                             UPD,
  output logic                             BUSY
`ifdef ILLEGAL_OP_FLAG_EN
  ,
  output logic                             OP_ERR
`endif
);

  // Internal arithmetic width: large enough for count + value + modulus
  // without any intermediate truncation.
  localparam int         AW       = 19;
  localparam logic [AW-1:0] DAY   = AW'(day_sec);
  localparam logic [16:0] HOUR_SEC = 17'd3600;
  localparam logic [16:0] MIN_SEC  = 17'd60;

  // --------------------------------------------------------------------------
  // Operation decode
  // --------------------------------------------------------------------------
  logic [oper_l-1:0]         op;
  logic [time_buff_size-1:0] val;
  logic [AW-1:0]             val_ext;
  logic [AW-1:0]             cnt_ext;
  logic                      is_reset;
  logic                      is_dec;
  logic                      is_add;
  logic                      val_ok;
  logic                      legal;

  assign op       = OPER[oper_l-1:0];
  assign val      = OPER[time_buff_size+oper_l-1:oper_l];
  assign val_ext  = AW'(val);
  assign cnt_ext  = AW'(TIME_CNT);
  assign is_reset = (op == oper_l'(1));
  assign is_dec   = (op == oper_l'(2));
  assign is_add   = (op == oper_l'(4));
  assign val_ok   = (val_ext < DAY);
  // Opcode must be exactly one-hot; ADD/DEC additionally need an in-range value.
  assign legal    = OPER_VALID && (is_reset || ((is_dec || is_add) && val_ok));

  // --------------------------------------------------------------------------
  // Next-count arithmetic: ADD/DEC first, then TICK on the result
  // --------------------------------------------------------------------------
  logic [AW-1:0] sum;
  logic [AW-1:0] after_op;
  logic [AW-1:0] ticked;
  logic [AW-1:0] next_cnt;

  always_comb begin
    sum      = cnt_ext + val_ext;
    after_op = cnt_ext;
    if (legal && is_add) begin
      after_op = (sum >= DAY) ? (sum - DAY) : sum;
    end else if (legal && is_dec) begin
      // Borrowing a full day keeps the result in range when val > count.
      after_op = (cnt_ext >= val_ext) ? (cnt_ext - val_ext)
                                      : (cnt_ext + DAY - val_ext);
    end
    ticked = after_op + AW'(1);
    if (TICK) begin
      next_cnt = (ticked == DAY) ? '0 : ticked;
    end else begin
      next_cnt = after_op;
    end
    // RESET overrides everything, including a coincident TICK.
    if (legal && is_reset) begin
      next_cnt = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Counter register. cnt_changed marks the edge on which the count moved so
  // the converter can reload on the following edge.
  // --------------------------------------------------------------------------
  logic cnt_changed;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      TIME_CNT    <= '0;
      cnt_changed <= 1'b0;
    end else begin
      TIME_CNT    <= next_cnt[16:0];
      cnt_changed <= (next_cnt[16:0] != TIME_CNT);
    end
  end

  // --------------------------------------------------------------------------
  // Sticky illegal-operation flag
  // --------------------------------------------------------------------------
`ifdef ILLEGAL_OP_FLAG_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OP_ERR <= 1'b0;
    end else if (OPER_VALID && !legal) begin
      OP_ERR <= 1'b1;
    end else if (legal && is_reset) begin
      OP_ERR <= 1'b0;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Seconds -> H:M:S converter. Repeated subtraction of 3600 then 60; the
  // leftover is the seconds field. A count change at any point restarts it
  // and the in-flight result is dropped.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_H = 2'd1,
    CONV_M = 2'd2
  } conv_state_t;

  conv_state_t state;
  logic [16:0] rem;
  logic [4:0]  h_acc;
  logic [5:0]  m_acc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      rem    <= '0;
      h_acc  <= '0;
      m_acc  <= '0;
      HOUR   <= '0;
      MINUTE <= '0;
      SECOND <= '0;
      UPD    <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      UPD <= 1'b0;
      if (cnt_changed) begin
        rem   <= TIME_CNT;
        h_acc <= '0;
        m_acc <= '0;
        state <= CONV_H;
        BUSY  <= 1'b1;
      end else begin
        case (state)
          CONV_H: begin
            if (rem >= HOUR_SEC) begin
              rem   <= rem - HOUR_SEC;
              h_acc <= h_acc + 5'd1;
            end else begin
              state <= CONV_M;
            end
          end
          CONV_M: begin
            if (rem >= MIN_SEC) begin
              rem   <= rem - MIN_SEC;
              m_acc <= m_acc + 6'd1;
            end else begin
              // rem < 60 here, so the low six bits hold the whole value.
              HOUR   <= h_acc;
              MINUTE <= m_acc;
              SECOND <= rem[5:0];
              UPD    <= 1'b1;
              BUSY   <= 1'b0;
              state  <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
